// File: rtl/vliw_pkg.sv
// ----------------------------------------------------------------------------
// vliw_pkg
//   Shared widths and the result-bundle record used by the VLIW writeback
//   buffer and its sub-modules.
//   DATA_W / ADDR_W : register data / address width
//   NUM_RD          : number of register-file operand read ports
//   wb_bundle_t     : one execute bundle, two slot writes {we, wa, wd}
// ----------------------------------------------------------------------------
package vliw_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 3;

    typedef struct packed {
        logic              we1;
        logic [ADDR_W-1:0] wa1;
        logic [DATA_W-1:0] wd1;
        logic              we2;
        logic [ADDR_W-1:0] wa2;
        logic [DATA_W-1:0] wd2;
    } wb_bundle_t;

endpackage

// File: rtl/wb_bundle_fifo.sv
// ----------------------------------------------------------------------------
// wb_bundle_fifo
//   DEPTH-entry circular store of result bundles with read/write pointers and
//   an occupancy count. Every entry is exposed in age order (index 0 = head,
//   the oldest) together with a valid mask, so the forwarding muxes can search
//   without knowing where the pointers sit.
// Ports
//   CLK, nRESET   clock, asynchronous active-low reset
//   push          store push_bundle at the tail (ignored when full)
//   push_bundle   bundle to store
//   pop           retire the head (ignored when empty)
//   age_entry     all entries, oldest first
//   age_valid     per age slot: entry holds a live bundle
//   count         bundles held, 0..DEPTH
// ----------------------------------------------------------------------------
module wb_bundle_fifo
    import vliw_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        nRESET,
    input  logic                        push,
    input  wb_bundle_t                  push_bundle,
    input  logic                        pop,
    output wb_bundle_t [DEPTH-1:0]      age_entry,
    output logic       [DEPTH-1:0]      age_valid,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_bundle_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push_ok, pop_ok;

    // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
    assign push_ok = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop  && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_bundle;
            // DEPTH is a power of two, so the pointer wraps by overflow.
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Rotate storage into age order; a slot is live when its age is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry[i] = mem_q[rd_ptr_q + PTR_W'(i)];
            age_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_fwd_mux.sv
// ----------------------------------------------------------------------------
// wb_fwd_mux
//   Operand bypass for one read port. Returns the data of the youngest live
//   buffered write to rd_addr, slot 2 beating slot 1 inside a bundle, else
//   the register-file value.
// Ports
//   age_entry   buffered bundles, oldest first
//   age_valid   live mask, same order
//   rd_addr     operand address
//   rf_data     register-file read data for rd_addr
//   fwd_data    bypassed operand
// ----------------------------------------------------------------------------
module wb_fwd_mux
    import vliw_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wb_bundle_t [DEPTH-1:0] age_entry,
    input  logic       [DEPTH-1:0] age_valid,
    input  logic      [ADDR_W-1:0] rd_addr,
    input  logic      [DATA_W-1:0] rf_data,
    output logic      [DATA_W-1:0] fwd_data
);

    // Walk oldest to youngest and let each later hit overwrite the earlier one;
    // checking slot 2 after slot 1 gives it priority within a bundle.
    always_comb begin
        fwd_data = rf_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i]) begin
                if (age_entry[i].we1 && (age_entry[i].wa1 == rd_addr)) begin
                    fwd_data = age_entry[i].wd1;
                end
                if (age_entry[i].we2 && (age_entry[i].wa2 == rd_addr)) begin
                    fwd_data = age_entry[i].wd2;
                end
            end
        end
    end

endmodule

// File: rtl/vliw_writeback_buffer.sv
// ----------------------------------------------------------------------------
// vliw_writeback_buffer
//   Writeback stage between the two VLIW execute slots and a 2-write/3-read
//   register file. Buffers up to DEPTH bundles, commits the head to the RF
//   write ports, suppresses slot 1 when both slots hit the same register,
//   and bypasses pending results onto the three operand read ports.
//   Register widths come from vliw_pkg.
// Ports
//   CLK, nRESET                 clock, asynchronous active-low reset
//   InValid / InReady           execute bundle handshake (ready from state only)
//   InWE1/2, InWA1/2, InWD1/2   slot 1/2 result write
//   Stall                       hold commit this cycle
//   WriteEnable1/2, WriteAddress1/2, WriteData1/2   RF write ports
//   ReadAddress1/2/3, RfData1/2/3                   RF read ports
//   FwdData1/2/3                bypassed operands
//   Occupancy                   bundles held
// ----------------------------------------------------------------------------
module vliw_writeback_buffer
    import vliw_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic                 InWE1,
    input  logic                 InWE2,
    input  logic    [ADDR_W-1:0] InWA1,
    input  logic    [ADDR_W-1:0] InWA2,
    input  logic    [DATA_W-1:0] InWD1,
    input  logic    [DATA_W-1:0] InWD2,
    input  logic                 Stall,
    output logic                 WriteEnable1,
    output logic                 WriteEnable2,
    output logic    [ADDR_W-1:0] WriteAddress1,
    output logic    [ADDR_W-1:0] WriteAddress2,
    output logic    [DATA_W-1:0] WriteData1,
    output logic    [DATA_W-1:0] WriteData2,
    input  logic    [ADDR_W-1:0] ReadAddress1,
    input  logic    [ADDR_W-1:0] ReadAddress2,
    input  logic    [ADDR_W-1:0] ReadAddress3,
    input  logic    [DATA_W-1:0] RfData1,
    input  logic    [DATA_W-1:0] RfData2,
    input  logic    [DATA_W-1:0] RfData3,
    output logic    [DATA_W-1:0] FwdData1,
    output logic    [DATA_W-1:0] FwdData2,
    output logic    [DATA_W-1:0] FwdData3,
    output logic [$clog2(DEPTH):0] Occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_bundle_t                    in_bundle;
    wb_bundle_t                    head;
    wb_bundle_t [DEPTH-1:0]        age_entry;
    logic       [DEPTH-1:0]        age_valid;
    logic       [CNT_W-1:0]        count;
    logic                          push;
    logic                          commit;
    logic                          conflict;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rf_data;
    logic [NUM_RD-1:0][DATA_W-1:0] fwd_data;

    always_comb begin
        in_bundle     = '0;
        in_bundle.we1 = InWE1;
        in_bundle.wa1 = InWA1;
        in_bundle.wd1 = InWD1;
        in_bundle.we2 = InWE2;
        in_bundle.wa2 = InWA2;
        in_bundle.wd2 = InWD2;
    end

    // Ready looks only at the stored count: a full buffer refuses a bundle
    // even in a cycle where the head retires, keeping Stall off this path.
    assign InReady = (count < CNT_W'(DEPTH));
    assign push    = InValid && InReady;

    // age_valid[0] is the "buffer not empty" flag.
    assign commit  = age_valid[0] && !Stall;

    wb_bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .push        (push),
        .push_bundle (in_bundle),
        .pop         (commit),
        .age_entry   (age_entry),
        .age_valid   (age_valid),
        .count       (count)
    );

    assign head     = age_entry[0];
    // Same-register double write in one bundle: slot 2 is the architectural winner.
    assign conflict = head.we1 && head.we2 && (head.wa1 == head.wa2);

    assign WriteEnable1  = commit && head.we1 && !conflict;
    assign WriteEnable2  = commit && head.we2;
    assign WriteAddress1 = head.wa1;
    assign WriteAddress2 = head.wa2;
    assign WriteData1    = head.wd1;
    assign WriteData2    = head.wd2;
    assign Occupancy     = count;

    assign rd_addr = {ReadAddress3, ReadAddress2, ReadAddress1};
    assign rf_data = {RfData3, RfData2, RfData1};

    // The head stays in the search while it commits: the RF only sees the
    // write at the next edge, so the buffered copy is still the live value.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_fwd
        wb_fwd_mux #(.DEPTH(DEPTH)) u_fwd (
            .age_entry (age_entry),
            .age_valid (age_valid),
            .rd_addr   (rd_addr[k]),
            .rf_data   (rf_data[k]),
            .fwd_data  (fwd_data[k])
        );
    end

    assign FwdData1 = fwd_data[0];
    assign FwdData2 = fwd_data[1];
    assign FwdData3 = fwd_data[2];

endmodule

// File: tb/tb_vliw_writeback_buffer.sv
module tb_vliw_writeback_buffer;

    localparam int DEPTH = 2;

    logic       CLK, nRESET;
    logic       InValid, InReady, InWE1, InWE2, Stall;
    logic [3:0] InWA1, InWA2;
    logic [7:0] InWD1, InWD2;
    logic       WriteEnable1, WriteEnable2;
    logic [3:0] WriteAddress1, WriteAddress2;
    logic [7:0] WriteData1, WriteData2;
    logic [3:0] ReadAddress1, ReadAddress2, ReadAddress3;
    logic [7:0] RfData1, RfData2, RfData3;
    logic [7:0] FwdData1, FwdData2, FwdData3;
    logic [1:0] Occupancy;

    vliw_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .InValid(InValid), .InReady(InReady),
        .InWE1(InWE1), .InWE2(InWE2), .InWA1(InWA1), .InWA2(InWA2),
        .InWD1(InWD1), .InWD2(InWD2), .Stall(Stall),
        .WriteEnable1(WriteEnable1), .WriteEnable2(WriteEnable2),
        .WriteAddress1(WriteAddress1), .WriteAddress2(WriteAddress2),
        .WriteData1(WriteData1), .WriteData2(WriteData2),
        .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2), .ReadAddress3(ReadAddress3),
        .RfData1(RfData1), .RfData2(RfData2), .RfData3(RfData3),
        .FwdData1(FwdData1), .FwdData2(FwdData2), .FwdData3(FwdData3),
        .Occupancy(Occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       we1;
        logic [3:0] wa1;
        logic [7:0] wd1;
        logic       we2;
        logic [3:0] wa2;
        logic [7:0] wd2;
    } mb_t;

    typedef struct {
        logic v; mb_t b; logic st; logic [3:0] ra; logic [7:0] rf;
        logic e_rdy; int e_occ; logic e_we1, e_we2;
        logic [3:0] e_wa; logic [7:0] e_wd, e_fwd;
    } vec_t;

    int  checks   = 0;
    int  failures = 0;
    mb_t mq[$];     // reference: pending bundles, oldest first
    vec_t tbl[19];

    function automatic mb_t bnd(input logic we1, input logic [3:0] wa1, input logic [7:0] wd1,
                                input logic we2, input logic [3:0] wa2, input logic [7:0] wd2);
        mb_t b;
        b.we1 = we1; b.wa1 = wa1; b.wd1 = wd1;
        b.we2 = we2; b.wa2 = wa2; b.wd2 = wd2;
        return b;
    endfunction

    function automatic vec_t vec(input logic v, input mb_t b, input logic st, input logic [3:0] ra,
                                 input logic [7:0] rf, input logic e_rdy, input int e_occ,
                                 input logic e_we1, input logic e_we2, input logic [3:0] e_wa,
                                 input logic [7:0] e_wd, input logic [7:0] e_fwd);
        vec_t r;
        r.v = v; r.b = b; r.st = st; r.ra = ra; r.rf = rf;
        r.e_rdy = e_rdy; r.e_occ = e_occ; r.e_we1 = e_we1; r.e_we2 = e_we2;
        r.e_wa = e_wa; r.e_wd = e_wd; r.e_fwd = e_fwd;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Youngest pending write to address a wins; slot 2 before slot 1 in a bundle.
    function automatic logic [7:0] mfwd(input logic [3:0] a, input logic [7:0] rf);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].we2 && mq[i].wa2 == a) return mq[i].wd2;
            if (mq[i].we1 && mq[i].wa1 == a) return mq[i].wd1;
        end
        return rf;
    endfunction

    // Drive one cycle's inputs just after the edge and let them settle.
    task automatic cyc(input logic v, input mb_t b, input logic st,
                       input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] ra3,
                       input logic [7:0] rf1, input logic [7:0] rf2, input logic [7:0] rf3);
        @(posedge CLK); #1;
        InValid = v; InWE1 = b.we1; InWA1 = b.wa1; InWD1 = b.wd1;
        InWE2 = b.we2; InWA2 = b.wa2; InWD2 = b.wd2; Stall = st;
        ReadAddress1 = ra1; ReadAddress2 = ra2; ReadAddress3 = ra3;
        RfData1 = rf1; RfData2 = rf2; RfData3 = rf3;
        #1;
    endtask

    // What the coming edge does to the reference queue.
    task automatic model_edge();
        logic rdy;
        rdy = (mq.size() < DEPTH);
        if (mq.size() > 0 && !Stall) mq.delete(0);
        if (InValid && rdy) mq.push_back(bnd(InWE1, InWA1, InWD1, InWE2, InWA2, InWD2));
    endtask

    task automatic chk_model();
        mb_t  h;
        logic c, e1, e2;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        c  = (mq.size() > 0) && !Stall;
        e1 = c && h.we1 && !(h.we2 && h.wa1 == h.wa2);
        e2 = c && h.we2;
        chk("m_ready", int'(InReady), int'(mq.size() < DEPTH));
        chk("m_occ", int'(Occupancy), mq.size());
        chk("m_we1", int'(WriteEnable1), int'(e1));
        chk("m_we2", int'(WriteEnable2), int'(e2));
        if (e1) begin
            chk("m_wa1", int'(WriteAddress1), int'(h.wa1));
            chk("m_wd1", int'(WriteData1), int'(h.wd1));
        end
        if (e2) begin
            chk("m_wa2", int'(WriteAddress2), int'(h.wa2));
            chk("m_wd2", int'(WriteData2), int'(h.wd2));
        end
        chk("m_fwd1", int'(FwdData1), int'(mfwd(ReadAddress1, RfData1)));
        chk("m_fwd2", int'(FwdData2), int'(mfwd(ReadAddress2, RfData2)));
        chk("m_fwd3", int'(FwdData3), int'(mfwd(ReadAddress3, RfData3)));
    endtask

    initial begin
        mb_t  z, rb;
        logic [3:0] ra1, ra2, ra3;
        z = '0;

        // Hand-derived cycles: basic commit, stall/full, conflict, forwarding age.
        tbl[0]  = vec(1, bnd(1,3,8'hAA,0,0,0), 0, 3, 8'h33, 1, 0, 0, 0, 0, 8'h00, 8'h33);
        tbl[1]  = vec(0, z,                    0, 3, 8'h33, 1, 1, 1, 0, 3, 8'hAA, 8'hAA);
        tbl[2]  = vec(0, z,                    0, 3, 8'h33, 1, 0, 0, 0, 0, 8'h00, 8'h33);
        tbl[3]  = vec(1, bnd(1,1,8'h10,0,0,0), 1, 1, 8'h5A, 1, 0, 0, 0, 0, 8'h00, 8'h5A);
        tbl[4]  = vec(1, bnd(1,2,8'h20,0,0,0), 1, 1, 8'h5A, 1, 1, 0, 0, 0, 8'h00, 8'h10);
        tbl[5]  = vec(1, bnd(1,4,8'h40,0,0,0), 1, 4, 8'h44, 0, 2, 0, 0, 0, 8'h00, 8'h44);
        tbl[6]  = vec(1, bnd(1,4,8'h40,0,0,0), 0, 2, 8'h22, 0, 2, 1, 0, 1, 8'h10, 8'h20);
        tbl[7]  = vec(0, z,                    0, 4, 8'h44, 1, 1, 1, 0, 2, 8'h20, 8'h44);
        tbl[8]  = vec(0, z,                    0, 4, 8'h44, 1, 0, 0, 0, 0, 8'h00, 8'h44);
        tbl[9]  = vec(1, bnd(1,5,8'h11,1,5,8'h22), 0, 5, 8'h55, 1, 0, 0, 0, 0, 8'h00, 8'h55);
        tbl[10] = vec(0, z,                    0, 5, 8'h55, 1, 1, 0, 1, 5, 8'h22, 8'h22);
        tbl[11] = vec(0, z,                    0, 5, 8'h55, 1, 0, 0, 0, 0, 8'h00, 8'h55);
        tbl[12] = vec(1, bnd(1,7,8'h01,0,0,0), 1, 7, 8'h07, 1, 0, 0, 0, 0, 8'h00, 8'h07);
        tbl[13] = vec(1, bnd(0,0,0,1,7,8'h02), 1, 7, 8'h07, 1, 1, 0, 0, 0, 8'h00, 8'h01);
        tbl[14] = vec(0, z,                    1, 7, 8'h07, 0, 2, 0, 0, 0, 8'h00, 8'h02);
        tbl[15] = vec(0, z,                    0, 7, 8'h07, 0, 2, 1, 0, 7, 8'h01, 8'h02);
        tbl[16] = vec(0, z,                    0, 7, 8'h07, 1, 1, 0, 1, 7, 8'h02, 8'h02);
        tbl[17] = vec(0, z,                    0, 7, 8'h77, 1, 0, 0, 0, 0, 8'h00, 8'h77);
        tbl[18] = vec(0, z,                    0, 7, 8'h99, 1, 0, 0, 0, 0, 8'h00, 8'h99);

        nRESET = 1'b0;
        InValid = 0; InWE1 = 0; InWE2 = 0; InWA1 = 0; InWA2 = 0; InWD1 = 0; InWD2 = 0;
        Stall = 0;
        ReadAddress1 = 4'h3; ReadAddress2 = 4'h6; ReadAddress3 = 4'h9;
        RfData1 = 8'h5C; RfData2 = 8'h6D; RfData3 = 8'h7E;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", int'(InReady), 1);
        chk("rst_occ", int'(Occupancy), 0);
        chk("rst_we1", int'(WriteEnable1), 0);
        chk("rst_we2", int'(WriteEnable2), 0);
        chk("rst_fwd1", int'(FwdData1), 8'h5C);
        chk("rst_fwd2", int'(FwdData2), 8'h6D);
        chk("rst_fwd3", int'(FwdData3), 8'h7E);
        nRESET = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].st, tbl[i].ra, tbl[i].ra, tbl[i].ra,
                tbl[i].rf, tbl[i].rf, tbl[i].rf);
            chk($sformatf("t%0d_ready", i), int'(InReady), int'(tbl[i].e_rdy));
            chk($sformatf("t%0d_occ", i), int'(Occupancy), tbl[i].e_occ);
            chk($sformatf("t%0d_we1", i), int'(WriteEnable1), int'(tbl[i].e_we1));
            chk($sformatf("t%0d_we2", i), int'(WriteEnable2), int'(tbl[i].e_we2));
            if (tbl[i].e_we1) begin
                chk($sformatf("t%0d_wa1", i), int'(WriteAddress1), int'(tbl[i].e_wa));
                chk($sformatf("t%0d_wd1", i), int'(WriteData1), int'(tbl[i].e_wd));
            end
            if (tbl[i].e_we2) begin
                chk($sformatf("t%0d_wa2", i), int'(WriteAddress2), int'(tbl[i].e_wa));
                chk($sformatf("t%0d_wd2", i), int'(WriteData2), int'(tbl[i].e_wd));
            end
            chk($sformatf("t%0d_fwd1", i), int'(FwdData1), int'(tbl[i].e_fwd));
            chk($sformatf("t%0d_fwd2", i), int'(FwdData2), int'(tbl[i].e_fwd));
            chk($sformatf("t%0d_fwd3", i), int'(FwdData3), int'(tbl[i].e_fwd));
            model_edge();
        end

        // Fill under stall, then stream one bundle per cycle from full.
        for (int i = 0; i < 16; i++) begin
            rb = bnd(1, 4'(i), 8'(8'h80 + i), 1, 4'(i + 1), 8'(8'hC0 + i));
            cyc(1, rb, (i < 2), 4'(i), 4'(i + 1), 4'(i + 2), 8'h01, 8'h02, 8'h03);
            chk_model();
            if (i >= 3) chk("stream_occ_range",
                            int'(Occupancy == 2'(DEPTH - 1) || Occupancy == 2'(DEPTH)), 1);
            model_edge();
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, z, 0, 0, 1, 2, 8'h01, 8'h02, 8'h03);
            chk_model();
            model_edge();
        end

        // Reset with two bundles held: immediate reset outputs, nothing commits after.
        cyc(1, bnd(1, 9, 8'h91, 0, 0, 0), 1, 9, 9, 9, 8'h09, 8'h09, 8'h09);
        model_edge();
        cyc(1, bnd(0, 0, 0, 1, 10, 8'hA2), 1, 9, 9, 9, 8'h09, 8'h09, 8'h09);
        model_edge();
        cyc(0, z, 0, 9, 10, 9, 8'h09, 8'h0A, 8'h09);
        chk_model();
        nRESET = 1'b0;
        #1;
        mq.delete();
        chk("arst_occ", int'(Occupancy), 0);
        chk("arst_ready", int'(InReady), 1);
        chk("arst_we1", int'(WriteEnable1), 0);
        chk("arst_we2", int'(WriteEnable2), 0);
        chk("arst_fwd1", int'(FwdData1), 8'h09);
        chk("arst_fwd2", int'(FwdData2), 8'h0A);
        @(posedge CLK); #1;
        nRESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, z, 0, 9, 10, 9, 8'h09, 8'h0A, 8'h09);
            chk_model();
            model_edge();
        end

        // Random traffic against the reference queue; small address space forces hits.
        for (int i = 0; i < 400; i++) begin
            rb = bnd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
            ra1 = 4'($urandom_range(0, 3));
            ra2 = 4'($urandom_range(0, 3));
            ra3 = 4'($urandom_range(0, 3));
            cyc(($urandom_range(0, 3) != 0), rb, ($urandom_range(0, 3) == 0),
                ra1, ra2, ra3, 8'($urandom), 8'($urandom), 8'($urandom));
            chk_model();
            model_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
